// File: rtl/mu0_pkg.sv
// Shared MU0 definitions: opcodes, ALU function codes and the control FSM state type.
// Also imported by the datapath so both sides agree on the ALU encoding.
package mu0_pkg;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;

  localparam logic [1:0] ALU_PASS_Y = 2'b00;
  localparam logic [1:0] ALU_ADD    = 2'b01;
  localparam logic [1:0] ALU_INC    = 2'b10;
  localparam logic [1:0] ALU_SUB    = 2'b11;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXECUTE = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

endpackage

// File: rtl/mu0_control.sv
// MU0 control unit: fetch/execute/halt FSM driving the datapath selects, enables,
// memory strobes and ALU function, plus a retired-instruction counter.
//
// Memory handshake: a request (MEM_rEn or MEM_wEn) is held high until the cycle in
// which mem_ack is 1; that cycle completes the access and is the only cycle in which
// the associated register enable fires. mem_ack outside a request is ignored.
module mu0_control
  import mu0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  F,
  input  logic        N,
  input  logic        Z,
  input  logic        mem_ack,
  output logic        X_sel,
  output logic        Y_sel,
  output logic        Addr_sel,
  output logic        PC_En,
  output logic        IR_En,
  output logic        Acc_En,
  output logic        MEM_rEn,
  output logic        MEM_wEn,
  output logic [1:0]  ALU_fs,
  output logic        Halted,
  output logic [15:0] instr_count,
  output state_t      dbg_state_o
);

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        is_mem_op;
  logic        exec_done;

  // Opcodes 0-3 are the ones that touch data memory.
  assign is_mem_op = (F[3:2] == 2'b00);
  assign exec_done = (state_q == ST_EXECUTE) && (!is_mem_op || mem_ack);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ack) state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (exec_done) begin
          state_d = (F == OP_STP) ? ST_HALT : ST_FETCH;
          count_d = count_q + 16'd1;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Outputs are forced low while reset is held, even though state_q already reads FETCH.
  always_comb begin
    X_sel    = 1'b0;
    Y_sel    = 1'b0;
    Addr_sel = 1'b0;
    PC_En    = 1'b0;
    IR_En    = 1'b0;
    Acc_En   = 1'b0;
    MEM_rEn  = 1'b0;
    MEM_wEn  = 1'b0;
    ALU_fs   = ALU_PASS_Y;
    Halted   = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          MEM_rEn = 1'b1;
          X_sel   = 1'b1;
          ALU_fs  = ALU_INC;
          IR_En   = mem_ack;
          PC_En   = mem_ack;
        end
        ST_EXECUTE: begin
          case (F)
            OP_LDA: begin
              Addr_sel = 1'b1;
              MEM_rEn  = 1'b1;
              ALU_fs   = ALU_PASS_Y;
              Acc_En   = mem_ack;
            end
            OP_STA: begin
              Addr_sel = 1'b1;
              MEM_wEn  = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              Addr_sel = 1'b1;
              MEM_rEn  = 1'b1;
              ALU_fs   = (F == OP_ADD) ? ALU_ADD : ALU_SUB;
              Acc_En   = mem_ack;
            end
            OP_JMP, OP_JGE, OP_JNE: begin
              Y_sel  = 1'b1;
              ALU_fs = ALU_PASS_Y;
              PC_En  = (F == OP_JMP) ? 1'b1 : (F == OP_JGE) ? ~N : ~Z;
            end
            default: ;
          endcase
        end
        ST_HALT: Halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign instr_count = count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mu0_control.sv
// Randomized bench for mu0_control: an instruction-level model pushes the expected
// per-cycle output bundle into a queue, and a negedge monitor compares the DUT to it.
module tb_mu0_control;
  import mu0_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  F = 4'd0;
  logic        N = 1'b0;
  logic        Z = 1'b0;
  logic        mem_ack = 1'b0;
  logic        X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, MEM_rEn, MEM_wEn, Halted;
  logic [1:0]  ALU_fs;
  logic [15:0] instr_count;
  state_t      dbg_state;

  // {X,Y,Addr,PC_En,IR_En,Acc_En,rEn,wEn,ALU_fs[1:0],Halted,instr_count[15:0]}
  logic [27:0] exp_q[$];
  logic [15:0] model_count = 16'd0;
  int          tests = 0;
  int          failed = 0;

  mu0_control dut (
    .clk(clk), .reset(reset), .F(F), .N(N), .Z(Z), .mem_ack(mem_ack),
    .X_sel(X_sel), .Y_sel(Y_sel), .Addr_sel(Addr_sel),
    .PC_En(PC_En), .IR_En(IR_En), .Acc_En(Acc_En),
    .MEM_rEn(MEM_rEn), .MEM_wEn(MEM_wEn), .ALU_fs(ALU_fs),
    .Halted(Halted), .instr_count(instr_count), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] vec(input logic x, input logic y, input logic a,
                                      input logic pc, input logic ir, input logic acc,
                                      input logic r, input logic w, input logic [1:0] fs,
                                      input logic h, input logic [15:0] cnt);
    return {x, y, a, pc, ir, acc, r, w, fs, h, cnt};
  endfunction

  // Expected EXECUTE-cycle bundle, from the instruction's class.
  function automatic logic [27:0] exec_vec(input logic [3:0] op, input logic n, input logic z,
                                           input logic ack, input logic [15:0] cnt);
    case (op)
      4'd0: return vec(0, 0, 1, 0, 0, ack, 1, 0, ALU_PASS_Y, 0, cnt);
      4'd1: return vec(0, 0, 1, 0, 0, 0, 0, 1, ALU_PASS_Y, 0, cnt);
      4'd2: return vec(0, 0, 1, 0, 0, ack, 1, 0, ALU_ADD, 0, cnt);
      4'd3: return vec(0, 0, 1, 0, 0, ack, 1, 0, ALU_SUB, 0, cnt);
      4'd4: return vec(0, 1, 0, 1, 0, 0, 0, 0, ALU_PASS_Y, 0, cnt);
      4'd5: return vec(0, 1, 0, ~n, 0, 0, 0, 0, ALU_PASS_Y, 0, cnt);
      4'd6: return vec(0, 1, 0, ~z, 0, 0, 0, 0, ALU_PASS_Y, 0, cnt);
      default: return vec(0, 0, 0, 0, 0, 0, 0, 0, ALU_PASS_Y, 0, cnt);
    endcase
  endfunction

  task automatic apply(input logic rst, input logic [3:0] f, input logic n, input logic z,
                       input logic ack, input logic [27:0] e);
    reset = rst;
    F = f;
    N = n;
    Z = z;
    mem_ack = ack;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      model_count = 16'd0;
      apply(1'b1, 4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)),
            1'($urandom_range(1)), 28'd0);
    end
  endtask

  task automatic do_fetch(input int waits, input bit preset);
    logic ack;
    for (int i = 0; i <= waits; i++) begin
      @(posedge clk); #1;
      if (preset && i == 0) begin
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        model_count = 16'hFFFF;
      end
      ack = (i == waits);
      apply(1'b0, 4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)),
            ack, vec(1, 0, 0, ack, ack, 0, 1, 0, ALU_INC, 0, model_count));
    end
  endtask

  task automatic do_exec(input logic [3:0] op, input logic n, input logic z, input int waits);
    logic ack;
    if (op < 4'd4) begin
      for (int i = 0; i <= waits; i++) begin
        @(posedge clk); #1;
        ack = (i == waits);
        apply(1'b0, op, n, z, ack, exec_vec(op, n, z, ack, model_count));
      end
    end else begin
      @(posedge clk); #1;
      ack = 1'($urandom_range(1));
      apply(1'b0, op, n, z, ack, exec_vec(op, n, z, ack, model_count));
    end
    model_count = model_count + 16'd1;
  endtask

  task automatic do_exec_stall(input logic [3:0] op, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      apply(1'b0, op, 1'b0, 1'b0, 1'b0, exec_vec(op, 1'b0, 1'b0, 1'b0, model_count));
    end
  endtask

  task automatic do_halt(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      apply(1'b0, 4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)),
            1'($urandom_range(1)), vec(0, 0, 0, 0, 0, 0, 0, 0, ALU_PASS_Y, 1, model_count));
    end
  endtask

  task automatic run_instr(input logic [3:0] op, input logic n, input logic z,
                           input int fw, input int ew);
    do_fetch(fw, 1'b0);
    do_exec(op, n, z, ew);
  endtask

  always @(negedge clk) begin
    logic [27:0] e, got;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      got = {X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, MEM_rEn, MEM_wEn,
             ALU_fs, Halted, instr_count};
      tests++;
      if (got !== e) begin
        failed++;
        $display("FAIL outputs t=%0t got=%h expected=%h (cnt got %h exp %h)",
                 $time, got, e, got[15:0], e[15:0]);
      end
    end
  end

  initial begin
    logic [3:0] op;
    do_reset(2);

    // Zero-wait program LDA, ADD, STA, STP, then absorbed in HALT
    run_instr(OP_LDA, 0, 0, 0, 0);
    run_instr(OP_ADD, 0, 0, 0, 0);
    run_instr(OP_STA, 0, 0, 0, 0);
    run_instr(OP_STP, 0, 0, 0, 0);
    do_halt(4);

    do_reset(2);
    run_instr(4'hA, 0, 0, 3, 0);
    run_instr(OP_JGE, 1, 0, 0, 0);
    run_instr(OP_JGE, 0, 1, 1, 0);
    run_instr(OP_JNE, 0, 1, 0, 0);
    run_instr(OP_JNE, 1, 0, 0, 0);
    run_instr(OP_JMP, 1, 1, 2, 0);
    run_instr(OP_LDA, 0, 0, 1, 2);
    run_instr(OP_STA, 0, 0, 0, 3);
    run_instr(OP_SUB, 0, 0, 2, 1);

    // Reset mid-EXECUTE of ADD while awaiting mem_ack
    do_fetch(0, 1'b0);
    do_exec_stall(OP_ADD, 2);
    do_reset(1);
    run_instr(OP_ADD, 0, 0, 0, 0);

    for (int k = 0; k < 150; k++) begin
      op = 4'($urandom_range(15));
      if (op == OP_STP && $urandom_range(3) != 0) op = 4'hB;
      run_instr(op, 1'($urandom_range(1)), 1'($urandom_range(1)),
                $urandom_range(2), $urandom_range(2));
      if (op == OP_STP) begin
        do_halt(2);
        do_reset(1);
      end
    end

    // Counter wrap: preset to 0xFFFF, retire a no-op and a jump
    do_fetch(0, 1'b1);
    do_exec(4'hC, 0, 0, 0);
    run_instr(OP_JMP, 0, 0, 0, 0);
    run_instr(OP_STP, 0, 0, 0, 0);
    do_halt(2);

    @(posedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mu0_control.md
# mu0_control

MU0 16-bit processor control unit: a fetch/execute state machine that decodes the 4-bit opcode and drives every mux select, register enable, memory strobe and ALU function code in the datapath. It sits directly upstream of the datapath 2-to-1 muxes and supplies their `S` inputs (`X_sel`, `Y_sel`, `Addr_sel`). It also adds a memory acknowledge handshake, a halt state and a retired-instruction counter.

## Interface
- No parameters. Widths are fixed by the MU0 ISA.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high.
- `F` in 4: opcode, IR[15:12].
- `N` in 1: accumulator negative flag (Acc[15]).
- `Z` in 1: accumulator zero flag.
- `mem_ack` in 1: memory has completed the current read or write this cycle.
- `X_sel` out 1: ALU X mux (0 = Acc, 1 = PC).
- `Y_sel` out 1: ALU Y mux (0 = memory read data, 1 = IR).
- `Addr_sel` out 1: address mux (0 = PC, 1 = IR[11:0]).
- `PC_En`, `IR_En`, `Acc_En` out 1 each: register load enables.
- `MEM_rEn`, `MEM_wEn` out 1 each: memory read and write requests.
- `ALU_fs` out 2: ALU function. 00 = pass Y, 01 = X+Y, 10 = X+1, 11 = X−Y.
- `Halted` out 1: processor stopped.
- `instr_count` out 16: number of instructions retired.

## Operation
- States: FETCH, EXECUTE, HALT.
- All outputs are combinational from state, `F`, `N`, `Z` and `mem_ack`.
- Select outputs not listed for a case below are 0.
- **FETCH:**
  - Drives `Addr_sel`=0, `MEM_rEn`=1, `X_sel`=1, `ALU_fs`=10.
  - `IR_En` and `PC_En` are 1 only when `mem_ack`=1.
  - On `mem_ack` → EXECUTE; otherwise stay in FETCH with the request held.
- **EXECUTE, by `F`:**
  - 0 LDA: `Addr_sel`=1, `MEM_rEn`=1, `Y_sel`=0, `ALU_fs`=00, `Acc_En`=`mem_ack`.
  - 1 STA: `Addr_sel`=1, `MEM_wEn`=1.
  - 2 ADD: `Addr_sel`=1, `MEM_rEn`=1, `X_sel`=0, `Y_sel`=0, `ALU_fs`=01, `Acc_En`=`mem_ack`.
  - 3 SUB: as ADD with `ALU_fs`=11.
  - 4 JMP: `Y_sel`=1, `ALU_fs`=00, `PC_En`=1.
  - 5 JGE: as JMP, but `PC_En`=~`N`.
  - 6 JNE: as JMP, but `PC_En`=~`Z`.
  - 7 STP: all enables and strobes 0; next state HALT.
  - 8–15: no-op; all enables and strobes 0.
- **EXECUTE completion:**
  - Memory opcodes (0–3) hold the request until `mem_ack`=1, then → FETCH.
  - Opcodes 4–6 and 8–15 complete in one cycle → FETCH.
- **HALT:**
  - Absorbing; leaves only on `reset`.
  - `Halted`=1; all enables and strobes 0; `mem_ack` ignored.
- **`instr_count`:**
  - Increments by 1 on the edge where EXECUTE completes. This includes STP (EXECUTE→HALT) and no-ops.
  - Wraps 0xFFFF → 0x0000.
  - Frozen in HALT.
- **Undefined cases:**
  - `mem_ack` outside a memory request is ignored.
  - `mem_ack` is never required to be low before a new request.

## Timing
- **Reset:**
  - While `reset`=1, state is FETCH, `instr_count`=0, and every output is forced 0, including `MEM_rEn`.
  - On the first cycle after release, the FETCH request is visible.
- **Latency:**
  - Minimum instruction time is 2 cycles: fetch ack in cycle 1, then execute.
  - Memory instructions with zero wait states take 2 cycles.
  - Each wait cycle on either access adds 1 cycle.
- **Register enables:** `IR_En`, `PC_En` (fetch) and `Acc_En` are asserted for exactly one cycle per access: the `mem_ack` cycle. No double loads.
- **Reset mid-access:** reset asserted during any state aborts the access immediately (asynchronous). The instruction is not counted.
- **Stable inputs:** `F` is read only in EXECUTE. `N` and `Z` are sampled in the same cycle as the jump decision.

## Structure
- Shared package `mu0_pkg`:
  - opcode constants (`OP_LDA` … `OP_STP`);
  - `ALU_fs` encodings;
  - state enum.
- The datapath reuses the ALU encodings from the package.
- One flat module. No sub-module is warranted; the 16-bit counter stays inline.

## Test plan
- Reset released with `mem_ack` tied 1 and program LDA 0x005, ADD 0x006, STA 0x007, STP: `instr_count`=4, `Halted`=1 after 8 cycles, and exactly one `MEM_wEn` pulse with `Addr_sel`=1.
- FETCH with `mem_ack` low for 3 cycles: `MEM_rEn` held 4 cycles, and `IR_En`/`PC_En` high only in the 4th cycle.
- JGE with `N`=1 → `PC_En`=0. JGE with `N`=0 → `PC_En`=1, `Y_sel`=1, `ALU_fs`=00. JNE with `Z`=1 → `PC_En`=0.
- Opcode 0xA: one-cycle EXECUTE, no enables or strobes, `instr_count` +1.
- `reset` pulsed mid-EXECUTE of ADD while awaiting `mem_ack`: all outputs 0 at once, `instr_count`=0, FETCH restarts after release.
- Counter preset to 0xFFFF (run 65535 no-ops), then one more instruction: `instr_count`=0x0000.
